// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-to-one memory arbiter.
// Holds the FSM state and owner encodings, plus the default memory
// interface widths that the caches also use.
package mem_arbiter_pkg;

    // Memory interface defaults: line-beat address, bus width, beats per line
    localparam int MEM_ADDR_W = 28;
    localparam int MEM_DATA_W = 128;
    localparam int MEM_BEATS  = 4;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_REQ   = 2'd1,
        ARB_WDATA = 2'd2,
        ARB_RRESP = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-to-one arbiter between the instruction-cache and data-cache miss
// ports and the single shared memory port. Each transaction is one request
// followed by BEATS write-data beats (rw=1) or BEATS read-response beats
// (rw=0). Read responses are routed to the cache that owns the transaction.
//
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   ic_req_* / dc_req_*            cache request and write-data channels
//   ic_resp_* / dc_resp_*          read-response beats toward each cache
//   mem_req_*                      request and write-data channel to memory
//   mem_resp_valid, mem_resp_data  read-response beats from memory
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W,
    parameter int MASK_W = DATA_W / 8,
    parameter int BEATS  = MEM_BEATS
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              ic_req_valid,
    output logic              ic_req_ready,
    input  logic [ADDR_W-1:0] ic_req_addr,
    input  logic              ic_req_rw,
    input  logic              ic_req_data_valid,
    output logic              ic_req_data_ready,
    input  logic [DATA_W-1:0] ic_req_data_bits,
    input  logic [MASK_W-1:0] ic_req_data_mask,
    output logic              ic_resp_valid,
    output logic [DATA_W-1:0] ic_resp_data,

    input  logic              dc_req_valid,
    output logic              dc_req_ready,
    input  logic [ADDR_W-1:0] dc_req_addr,
    input  logic              dc_req_rw,
    input  logic              dc_req_data_valid,
    output logic              dc_req_data_ready,
    input  logic [DATA_W-1:0] dc_req_data_bits,
    input  logic [MASK_W-1:0] dc_req_data_mask,
    output logic              dc_resp_valid,
    output logic [DATA_W-1:0] dc_resp_data,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_rw,
    output logic              mem_req_data_valid,
    input  logic              mem_req_data_ready,
    output logic [DATA_W-1:0] mem_req_data_bits,
    output logic [MASK_W-1:0] mem_req_data_mask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data
);

    localparam int              CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    arb_state_t       state;
    owner_t           owner;
    owner_t           last_grant;
    logic [CNT_W-1:0] beat_cnt;

    // Owner-selected view of the two cache ports
    logic              sel_req_valid;
    logic [ADDR_W-1:0] sel_req_addr;
    logic              sel_req_rw;
    logic              sel_data_valid;
    logic [DATA_W-1:0] sel_data_bits;
    logic [MASK_W-1:0] sel_data_mask;

    assign sel_req_valid  = (owner == OWN_DC) ? dc_req_valid      : ic_req_valid;
    assign sel_req_addr   = (owner == OWN_DC) ? dc_req_addr       : ic_req_addr;
    assign sel_req_rw     = (owner == OWN_DC) ? dc_req_rw         : ic_req_rw;
    assign sel_data_valid = (owner == OWN_DC) ? dc_req_data_valid : ic_req_data_valid;
    assign sel_data_bits  = (owner == OWN_DC) ? dc_req_data_bits  : ic_req_data_bits;
    assign sel_data_mask  = (owner == OWN_DC) ? dc_req_data_mask  : ic_req_data_mask;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values and the block simulates the way it synthesises.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ARB_IDLE;
            owner      <= OWN_IC;
            last_grant <= OWN_IC;
            beat_cnt   <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    // Contention goes to whoever was not granted last, so a
                    // waiting loser always wins the next arbitration.
                    if (ic_req_valid && dc_req_valid) begin
                        owner <= (last_grant == OWN_IC) ? OWN_DC : OWN_IC;
                        state <= ARB_REQ;
                    end else if (ic_req_valid) begin
                        owner <= OWN_IC;
                        state <= ARB_REQ;
                    end else if (dc_req_valid) begin
                        owner <= OWN_DC;
                        state <= ARB_REQ;
                    end
                end
                ARB_REQ: begin
                    if (sel_req_valid && mem_req_ready) begin
                        last_grant <= owner;
                        beat_cnt   <= '0;
                        state      <= sel_req_rw ? ARB_WDATA : ARB_RRESP;
                    end
                end
                ARB_WDATA: begin
                    if (sel_data_valid && mem_req_data_ready) begin
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt <= '0;
                            state    <= ARB_IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                ARB_RRESP: begin
                    if (mem_resp_valid) begin
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt <= '0;
                            state    <= ARB_IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Zero-latency routing; everything is idle-zero outside its own phase,
    // which also drops stray memory responses outside RRESP.
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        ic_req_ready       = 1'b0;
        dc_req_ready       = 1'b0;
        ic_req_data_ready  = 1'b0;
        dc_req_data_ready  = 1'b0;
        ic_resp_valid      = 1'b0;
        dc_resp_valid      = 1'b0;
        ic_resp_data       = '0;
        dc_resp_data       = '0;
        mem_req_valid      = 1'b0;
        mem_req_addr       = '0;
        mem_req_rw         = 1'b0;
        mem_req_data_valid = 1'b0;
        mem_req_data_bits  = '0;
        mem_req_data_mask  = '0;

        case (state)
            ARB_REQ: begin
                mem_req_valid = sel_req_valid;
                mem_req_addr  = sel_req_addr;
                mem_req_rw    = sel_req_rw;
                ic_req_ready  = (owner == OWN_IC) && mem_req_ready;
                dc_req_ready  = (owner == OWN_DC) && mem_req_ready;
            end
            ARB_WDATA: begin
                mem_req_data_valid = sel_data_valid;
                mem_req_data_bits  = sel_data_bits;
                mem_req_data_mask  = sel_data_mask;
                ic_req_data_ready  = (owner == OWN_IC) && mem_req_data_ready;
                dc_req_data_ready  = (owner == OWN_DC) && mem_req_data_ready;
            end
            ARB_RRESP: begin
                ic_resp_valid = (owner == OWN_IC) && mem_resp_valid;
                dc_resp_valid = (owner == OWN_DC) && mem_resp_valid;
                ic_resp_data  = mem_resp_data;
                dc_resp_data  = mem_resp_data;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter. Stimulus tasks push the expected memory
// requests, write beats and read responses into queues; a negedge monitor
// pops and compares whenever the DUT presents one of them.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;
    localparam int MASK_W = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              ic_req_valid = 1'b0, dc_req_valid = 1'b0;
    logic              ic_req_ready, dc_req_ready;
    logic [ADDR_W-1:0] ic_req_addr = '0, dc_req_addr = '0;
    logic              ic_req_rw = 1'b0, dc_req_rw = 1'b0;
    logic              ic_req_data_valid = 1'b0, dc_req_data_valid = 1'b0;
    logic              ic_req_data_ready, dc_req_data_ready;
    logic [DATA_W-1:0] ic_req_data_bits = '0, dc_req_data_bits = '0;
    logic [MASK_W-1:0] ic_req_data_mask = '0, dc_req_data_mask = '0;
    logic              ic_resp_valid, dc_resp_valid;
    logic [DATA_W-1:0] ic_resp_data, dc_resp_data;
    logic              mem_req_valid;
    logic              mem_req_ready = 1'b0;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_rw;
    logic              mem_req_data_valid;
    logic              mem_req_data_ready = 1'b0;
    logic [DATA_W-1:0] mem_req_data_bits;
    logic [MASK_W-1:0] mem_req_data_mask;
    logic              mem_resp_valid = 1'b0;
    logic [DATA_W-1:0] mem_resp_data = '0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready),
        .ic_req_addr(ic_req_addr), .ic_req_rw(ic_req_rw),
        .ic_req_data_valid(ic_req_data_valid), .ic_req_data_ready(ic_req_data_ready),
        .ic_req_data_bits(ic_req_data_bits), .ic_req_data_mask(ic_req_data_mask),
        .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready),
        .dc_req_addr(dc_req_addr), .dc_req_rw(dc_req_rw),
        .dc_req_data_valid(dc_req_data_valid), .dc_req_data_ready(dc_req_data_ready),
        .dc_req_data_bits(dc_req_data_bits), .dc_req_data_mask(dc_req_data_mask),
        .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_rw(mem_req_rw),
        .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
        .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    // own: 1 = DC, 0 = IC
    typedef struct packed { logic own; logic [ADDR_W-1:0] addr; logic rw; } req_exp_t;
    typedef struct packed { logic own; logic [DATA_W-1:0] bits; logic [MASK_W-1:0] mask; } wr_exp_t;
    typedef struct packed { logic own; logic [DATA_W-1:0] data; } resp_exp_t;

    req_exp_t  req_q[$];
    wr_exp_t   wr_q[$];
    resp_exp_t resp_q[$];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the queue heads
    always @(negedge clk) begin : monitor
        req_exp_t  re;
        wr_exp_t   we;
        resp_exp_t rp;
        if (!reset) begin
            if (mem_req_valid && mem_req_ready) begin
                if (req_q.size() == 0) check("unexpected_mem_req", mem_req_addr, '1);
                else begin
                    re = req_q.pop_front();
                    check("req_addr", mem_req_addr, re.addr);
                    check("req_rw", mem_req_rw, re.rw);
                    check("req_grant_ready", {ic_req_ready, dc_req_ready}, re.own ? 2'b01 : 2'b10);
                end
            end
            if (mem_req_data_valid && mem_req_data_ready) begin
                if (wr_q.size() == 0) check("unexpected_wr_beat", mem_req_data_bits, '1);
                else begin
                    we = wr_q.pop_front();
                    check("wr_bits", mem_req_data_bits, we.bits);
                    check("wr_mask", mem_req_data_mask, we.mask);
                    check("wr_owner_ready", {ic_req_data_ready, dc_req_data_ready}, we.own ? 2'b01 : 2'b10);
                end
            end
            if (ic_resp_valid || dc_resp_valid) begin
                if (resp_q.size() == 0) check("unexpected_resp", {ic_resp_valid, dc_resp_valid}, 2'b00);
                else begin
                    rp = resp_q.pop_front();
                    check("resp_route", {ic_resp_valid, dc_resp_valid}, rp.own ? 2'b01 : 2'b10);
                    check("ic_resp_data", ic_resp_data, rp.data);
                    check("dc_resp_data", dc_resp_data, rp.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic own, input logic v, input logic [ADDR_W-1:0] a, input logic rw);
        if (own) begin
            dc_req_valid = v; dc_req_addr = a; dc_req_rw = rw;
        end else begin
            ic_req_valid = v; ic_req_addr = a; ic_req_rw = rw;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Waits for the owner's request to fire; checks the loser stays un-ready
    task automatic wait_grant(input logic own, output int lat);
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("loser_ready_low", own ? ic_req_ready : dc_req_ready, 1'b0);
            if (mem_req_valid && mem_req_ready) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) check("grant_timeout", 1'b0, 1'b1);
        tick();
    endtask

    task automatic resp_beats(input logic own, input logic [DATA_W-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            resp_q.push_back('{own: own, data: base + DATA_W'(i)});
            mem_resp_valid = 1'b1;
            mem_resp_data  = base + DATA_W'(i);
            tick();
        end
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
    endtask

    task automatic single_read(input logic own, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] base);
        int lat;
        req_q.push_back('{own: own, addr: addr, rw: 1'b0});
        set_req(own, 1'b1, addr, 1'b0);
        wait_grant(own, lat);
        check("read_arb_latency", lat, 1);
        set_req(own, 1'b0, '0, 1'b0);
        resp_beats(own, base, 4);
        check("read_back_to_idle", dut.state, ARB_IDLE);
        check("read_idle_req_valid", mem_req_valid, 1'b0);
    endtask

    // DC write of beats 0x11..0x44 with mem_req_data_ready toggling 1/0
    task automatic dc_write_toggle(input logic [ADDR_W-1:0] addr, input logic stray);
        int   lat;
        int   sent;
        logic tog;
        req_q.push_back('{own: 1'b1, addr: addr, rw: 1'b1});
        for (int i = 0; i < 4; i++)
            wr_q.push_back('{own: 1'b1, bits: DATA_W'((i + 1) * 17), mask: 16'hFFFF});
        set_req(1'b1, 1'b1, addr, 1'b1);
        wait_grant(1'b1, lat);
        check("write_arb_latency", lat, 1);
        set_req(1'b1, 1'b0, '0, 1'b0);
        mem_resp_valid = stray;
        mem_resp_data  = DATA_W'('hDEAD);
        tog  = 1'b1;
        sent = 0;
        for (int cyc = 0; cyc < 40 && sent < 4; cyc++) begin
            dc_req_data_valid  = 1'b1;
            dc_req_data_bits   = DATA_W'((sent + 1) * 17);
            dc_req_data_mask   = 16'hFFFF;
            mem_req_data_ready = tog;
            @(negedge clk);
            check("dc_data_ready_mirror", dc_req_data_ready, tog);
            check("ic_data_ready_low", ic_req_data_ready, 1'b0);
            tick();
            if (tog) sent++;
            tog = ~tog;
        end
        dc_req_data_valid  = 1'b0;
        mem_req_data_ready = 1'b0;
        mem_resp_valid     = 1'b0;
        mem_resp_data      = '0;
        check("write_beats_sent", sent, 4);
        check("write_back_to_idle", dut.state, ARB_IDLE);
    endtask

    // Both caches hold valid; grants must alternate starting from DC
    task automatic both_reads(input int n);
        logic [ADDR_W-1:0] ic_a;
        logic [ADDR_W-1:0] dc_a;
        logic              own;
        int                lat;
        ic_a = 28'h0000100;
        dc_a = 28'h0000200;
        set_req(1'b0, 1'b1, ic_a, 1'b0);
        set_req(1'b1, 1'b1, dc_a, 1'b0);
        for (int k = 0; k < n; k++) begin
            own = ((k % 2) == 0);
            req_q.push_back('{own: own, addr: own ? dc_a : ic_a, rw: 1'b0});
            wait_grant(own, lat);
            check("both_arb_latency", lat, 1);
            if (own) begin
                dc_a = dc_a + 28'd1;
                dc_req_addr = dc_a;
            end else begin
                ic_a = ic_a + 28'd1;
                ic_req_addr = ic_a;
            end
            resp_beats(own, DATA_W'('hB0 + k * 16), 4);
        end
        set_req(1'b0, 1'b0, '0, 1'b0);
        set_req(1'b1, 1'b0, '0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        // Readies from memory held high so a stuck-ready bug would show
        mem_req_ready      = 1'b1;
        mem_req_data_ready = 1'b1;
        #12;
        check("rst_handshakes", {ic_req_ready, dc_req_ready, ic_req_data_ready, dc_req_data_ready,
                                 ic_resp_valid, dc_resp_valid, mem_req_valid, mem_req_data_valid}, 8'h00);
        check("rst_state", dut.state, ARB_IDLE);
        tick();
        reset = 1'b0;
        mem_req_data_ready = 1'b0;
        @(negedge clk);
        check("idle_handshakes", {ic_req_ready, dc_req_ready, mem_req_valid, mem_req_data_valid}, 4'h0);
        check("idle_addr_zero", mem_req_addr, '0);
        check("idle_data_zero", {mem_req_data_bits, mem_req_data_mask}, '0);
        tick();

        // Stray responses in IDLE are dropped and do not move the counter
        mem_resp_valid = 1'b1;
        mem_resp_data  = DATA_W'('hEE);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stray_idle_resp", {ic_resp_valid, dc_resp_valid}, 2'b00);
            check("stray_idle_data", ic_resp_data, '0);
            tick();
        end
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        check("stray_idle_cnt", dut.beat_cnt, 0);
        check("stray_idle_state", dut.state, ARB_IDLE);

        single_read(1'b0, 28'h0000123, DATA_W'('hA0));
        dc_write_toggle(28'h0000040, 1'b0);
        dc_write_toggle(28'h0000044, 1'b1);

        do_reset();
        both_reads(4);

        // Async reset after response beat 2 of an IC read
        req_q.push_back('{own: 1'b0, addr: 28'h0000ABC, rw: 1'b0});
        set_req(1'b0, 1'b1, 28'h0000ABC, 1'b0);
        wait_grant(1'b0, lat);
        set_req(1'b0, 1'b0, '0, 1'b0);
        resp_beats(1'b0, DATA_W'('hC0), 2);
        mem_resp_valid = 1'b1;
        mem_resp_data  = DATA_W'('hC2);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_resp_valid", {ic_resp_valid, dc_resp_valid}, 2'b00);
        check("midrst_resp_data", ic_resp_data, '0);
        check("midrst_state", dut.state, ARB_IDLE);
        check("midrst_cnt", dut.beat_cnt, 0);
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        tick();
        reset = 1'b0;
        single_read(1'b0, 28'h0000ABD, DATA_W'('hD0));

        tick();
        check("queues_drained", req_q.size() + wr_q.size() + resp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-to-one memory arbiter between the instruction cache and data cache miss ports and the single shared memory port.
- Sits directly downstream of both caches.
- Serialises whole transactions: one request, then either BEATS write-data beats or BEATS read-response beats.
- Routes read responses back to the cache that owns the transaction.

Parameters:
- ADDR_W, 28, memory line-beat address width (CPU word address minus 2 bits).
- DATA_W, 128, memory data bus width.
- MASK_W, DATA_W/8, byte mask width.
- BEATS, 4, data beats per cache line (read response or write data).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ic_req_valid / dc_req_valid  in  1  cache requests memory transaction
- ic_req_ready / dc_req_ready  out  1  request accepted this cycle
- ic_req_addr / dc_req_addr  in  ADDR_W  beat address
- ic_req_rw / dc_req_rw  in  1  1=write, 0=read
- ic_req_data_valid / dc_req_data_valid  in  1  write beat valid
- ic_req_data_ready / dc_req_data_ready  out  1  write beat accepted
- ic_req_data_bits / dc_req_data_bits  in  DATA_W  write beat data
- ic_req_data_mask / dc_req_data_mask  in  MASK_W  write byte mask
- ic_resp_valid / dc_resp_valid  out  1  read beat for this cache
- ic_resp_data / dc_resp_data  out  DATA_W  read beat data (broadcast)
- mem_req_valid  out  1
- mem_req_ready  in  1
- mem_req_addr  out  ADDR_W
- mem_req_rw  out  1
- mem_req_data_valid  out  1
- mem_req_data_ready  in  1
- mem_req_data_bits  out  DATA_W
- mem_req_data_mask  out  MASK_W
- mem_resp_valid  in  1
- mem_resp_data  in  DATA_W

Behaviour:
- Registered state: FSM state, owner (0=IC, 1=DC), beat counter (clog2(BEATS) bits), last_grant.
- Reset (async, active-high) forces state=IDLE, counter=0, last_grant=IC.
  - All valid/ready outputs are 0 during and after reset until the FSM leaves IDLE.
  - Address, data and mask outputs are 0 in IDLE.
- IDLE:
  - If exactly one req_valid is high, owner<=that cache.
  - If both are high, owner<=the cache not equal to last_grant. After reset this is DC.
  - Next state REQ. No ready is asserted in IDLE (1-cycle arbitration latency).
- REQ:
  - mem_req_valid/addr/rw = owner's signals; owner req_ready = mem_req_ready; the other cache's ready = 0.
  - On owner valid & mem_req_ready: last_grant<=owner, counter<=0; rw=1 -> WDATA, rw=0 -> RRESP.
  - Requesters hold valid/addr/rw stable until ready. A dropped owner valid keeps the FSM in REQ.
- WDATA:
  - mem_req_data_valid/bits/mask = owner's signals; owner data_ready = mem_req_data_ready.
  - On each beat fire, counter++. On fire with counter==BEATS-1 -> IDLE.
  - Writes produce no response.
- RRESP:
  - Owner resp_valid = mem_resp_valid; non-owner resp_valid = 0.
  - Both resp_data = mem_resp_data, combinational pass-through.
  - On each mem_resp_valid, counter++. On counter==BEATS-1 -> IDLE, counter wraps to 0.
- Cross-state rules:
  - mem_resp_valid outside RRESP is dropped and never routed to either cache.
  - A non-owner request waits with ready=0. A pending loser is granted on the next IDLE visit, which guarantees alternation when both caches request continuously.
- Routing latency is combinational (zero cycles) in every state. The only added latency is the one IDLE cycle per transaction.
- Reset mid-transaction abandons the transaction. No outstanding-beat bookkeeping survives reset.

Decomposition:
- Shared package holds:
  - state encodings: ARB_IDLE, ARB_REQ, ARB_WDATA, ARB_RRESP
  - owner encodings: OWN_IC=0, OWN_DC=1
  - default widths matching the memory interface constants used by the caches
- No sub-module. A single FSM plus a combinational output mux keyed on owner and state.

Test Plan:
- Single IC read addr 0x0000123, mem_req_ready=1 in REQ, 4 resp beats 0xA0..0xA3 -> ic_resp_valid high on exactly those 4 cycles with matching data; dc_resp_valid stays 0; FSM back to IDLE the cycle after beat 4.
- DC write addr 0x0000040, data beats 0x11..0x44, mask 0xFFFF, mem_req_data_ready toggling 1/0 -> exactly 4 beats delivered in order; dc_req_data_ready mirrors mem_req_data_ready; no resp_valid asserted.
- Both caches valid in the same cycle after reset -> DC granted first. IC is granted next; IC ready stays 0 until then.
- Both caches hold valid continuously for 4 read transactions -> grant order DC, IC, DC, IC.
- Stray mem_resp_valid in IDLE and in WDATA -> neither resp_valid asserts; counter unchanged.
- Reset asserted asynchronously after response beat 2 of an IC read -> outputs drop immediately; FSM=IDLE; next IC read completes normally with 4 beats.
